// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - parametrised single-port RAM behind the SPI slave
// Burst pointers wrap at MEM_DEPTH; the read path is one or two registered stages.
module spi_ram_burst #(
    parameter int MEM_WIDTH  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int ADDR_SIZE  = 8,
    parameter int AUTO_INC   = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_valid_i,
    input  logic [MEM_WIDTH+1:0] rx_data_i,
    output logic [MEM_WIDTH-1:0] dout_o,
    output logic                 tx_valid_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(MEM_DEPTH - 1);

    control_e               ctrl;
    logic [MEM_WIDTH-1:0]   d_in;
    logic [ADDR_SIZE-1:0]   addr;
    logic                   addr_ok;
    logic                   wr_cmd;
    logic                   rd_cmd;

    logic [MEM_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   err_q, err_d;
    logic [MEM_WIDTH-1:0]   dout_q;
    logic                   tx_valid_q;

    logic [MEM_WIDTH-1:0]   rd_word;
    logic                   out_vld;
    logic [MEM_WIDTH-1:0]   out_data;

    assign ctrl    = control_e'(rx_data_i[MEM_WIDTH+1:MEM_WIDTH]);
    assign d_in    = rx_data_i[MEM_WIDTH-1:0];
    assign addr    = d_in[ADDR_SIZE-1:0];
    assign addr_ok = ({1'b0, addr} < DEPTH_EXT);
    assign wr_cmd  = rx_valid_i && (ctrl == WR_DATA);
    assign rd_cmd  = rx_valid_i && (ctrl == RD_DATA);

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_IDX) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (rx_valid_i) begin
            unique case (ctrl)
                WR_ADDR: begin
                    if (addr_ok) wr_ptr_d = addr;
                    else         err_d    = 1'b1;
                end
                RD_ADDR: begin
                    if (addr_ok) rd_ptr_d = addr;
                    else         err_d    = 1'b1;
                end
                WR_DATA: if (AUTO_INC != 0) wr_ptr_d = next_ptr(wr_ptr_q);
                RD_DATA: if (AUTO_INC != 0) rd_ptr_d = next_ptr(rd_ptr_q);
                default: ;
            endcase
        end
    end

    // Array is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_cmd) mem[wr_ptr_q] <= d_in;
    end

    assign rd_word = mem[rd_ptr_q];

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 pipe_vld_q;
        logic [MEM_WIDTH-1:0] pipe_data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pipe_vld_q  <= 1'b0;
                pipe_data_q <= '0;
            end else begin
                pipe_vld_q <= rd_cmd;
                if (rd_cmd) pipe_data_q <= rd_word;
            end
        end

        assign out_vld  = pipe_vld_q;
        assign out_data = pipe_data_q;
    end else begin : g_lat1
        assign out_vld  = rd_cmd;
        assign out_data = rd_word;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            tx_valid_q <= out_vld;
            if (out_vld) dout_q <= out_data;
        end
    end

    assign dout_o     = dout_q;
    assign tx_valid_o = tx_valid_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb/tb_spi_ram_burst.sv - directed table-driven bench for spi_ram_burst
module tb_spi_ram_burst;

    localparam logic [1:0] WA = 2'b00;
    localparam logic [1:0] WD = 2'b01;
    localparam logic [1:0] RA = 2'b10;
    localparam logic [1:0] RD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld_a, vld_b, vld_c;
    logic [9:0] data_a, data_b, data_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       tx_a, tx_b, tx_c;
    logic       err_a, err_b, err_c;

    always #5 clk = ~clk;

    // a: defaults; b: 200-word depth; c: no auto-increment, two-cycle read
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1), .RD_LATENCY(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(vld_a), .rx_data_i(data_a),
        .dout_o(dout_a), .tx_valid_o(tx_a), .err_o(err_a));
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(200), .ADDR_SIZE(8), .AUTO_INC(1), .RD_LATENCY(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(vld_b), .rx_data_i(data_b),
        .dout_o(dout_b), .tx_valid_o(tx_b), .err_o(err_b));
    spi_ram_burst #(.MEM_WIDTH(8), .MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0), .RD_LATENCY(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(vld_c), .rx_data_i(data_c),
        .dout_o(dout_c), .tx_valid_o(tx_c), .err_o(err_c));

    typedef struct {
        int         dut;
        logic       vld;
        logic [1:0] ctrl;
        logic [7:0] d;
        logic       exp_tx;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input int dut, input logic vld, input logic [1:0] ctrl, input logic [7:0] d,
                       input logic etx, input logic [7:0] edout, input logic eerr);
        vec_t v;
        v.dut = dut; v.vld = vld; v.ctrl = ctrl; v.d = d;
        v.exp_tx = etx; v.exp_dout = edout; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int dut, input logic vld, input logic [1:0] ctrl, input logic [7:0] d);
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        case (dut)
            0: begin vld_a = vld; data_a = {ctrl, d}; end
            1: begin vld_b = vld; data_b = {ctrl, d}; end
            default: begin vld_c = vld; data_c = {ctrl, d}; end
        endcase
    endtask

    task automatic check_dut(input int dut, input string tag, input logic etx,
                             input logic [7:0] edout, input logic eerr);
        logic       t, e;
        logic [7:0] dv;
        case (dut)
            0: {t, dv, e} = {tx_a, dout_a, err_a};
            1: {t, dv, e} = {tx_b, dout_b, err_b};
            default: {t, dv, e} = {tx_c, dout_c, err_c};
        endcase
        check($sformatf("%s dut%0d tx_valid", tag, dut), {7'd0, t}, {7'd0, etx});
        check($sformatf("%s dut%0d dout", tag, dut), dv, edout);
        check($sformatf("%s dut%0d err", tag, dut), {7'd0, e}, {7'd0, eerr});
    endtask

    initial begin
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k, "reset", 1'b0, 8'h00, 1'b0);

        // burst write/read on a
        add(0, 1, WA, 8'h10, 0, 8'h00, 0);
        add(0, 1, WD, 8'hA5, 0, 8'h00, 0);
        add(0, 1, WD, 8'h5A, 0, 8'h00, 0);
        add(0, 1, RA, 8'h10, 0, 8'h00, 0);
        add(0, 1, RD, 8'h00, 1, 8'hA5, 0);
        add(0, 1, RD, 8'h00, 1, 8'h5A, 0);
        add(0, 0, RD, 8'h00, 0, 8'h5A, 0);
        // wrap at 0xFF on a; leaves wr_ptr=1, rd_ptr=1
        add(0, 1, WA, 8'hFF, 0, 8'h5A, 0);
        add(0, 1, WD, 8'h11, 0, 8'h5A, 0);
        add(0, 1, WD, 8'h22, 0, 8'h5A, 0);
        add(0, 1, RA, 8'hFF, 0, 8'h5A, 0);
        add(0, 1, RD, 8'h00, 1, 8'h11, 0);
        add(0, 1, RD, 8'h00, 1, 8'h22, 0);
        add(0, 1, WD, 8'h66, 0, 8'h22, 0);
        // rx_valid gating: RD_DATA control with valid low must do nothing
        for (int k = 0; k < 5; k++) add(0, 0, RD, 8'h00, 0, 8'h22, 0);
        add(0, 1, RD, 8'h00, 1, 8'h66, 0);
        // out-of-range and depth wrap on b
        add(1, 1, WA, 8'h05, 0, 8'h00, 0);
        add(1, 1, WA, 8'hC8, 0, 8'h00, 1);
        add(1, 1, WD, 8'h77, 0, 8'h00, 1);
        add(1, 1, RA, 8'h05, 0, 8'h00, 1);
        add(1, 1, RD, 8'h00, 1, 8'h77, 1);
        add(1, 1, WA, 8'hC7, 0, 8'h77, 1);
        add(1, 1, WD, 8'h01, 0, 8'h77, 1);
        add(1, 1, WD, 8'h02, 0, 8'h77, 1);
        add(1, 1, RA, 8'hC7, 0, 8'h77, 1);
        add(1, 1, RD, 8'h00, 1, 8'h01, 1);
        add(1, 1, RD, 8'h00, 1, 8'h02, 1);
        add(1, 1, RA, 8'h05, 0, 8'h02, 1);
        add(1, 1, RA, 8'hFF, 0, 8'h02, 1);
        add(1, 1, RD, 8'h00, 1, 8'h77, 1);
        // no auto-increment, two-cycle read on c
        add(2, 1, WA, 8'h03, 0, 8'h00, 0);
        add(2, 1, WD, 8'h3C, 0, 8'h00, 0);
        add(2, 1, WD, 8'hC3, 0, 8'h00, 0);
        add(2, 1, RA, 8'h03, 0, 8'h00, 0);
        add(2, 1, RD, 8'h00, 0, 8'h00, 0);
        add(2, 1, RD, 8'h00, 1, 8'hC3, 0);
        add(2, 1, RD, 8'h00, 1, 8'hC3, 0);
        add(2, 0, RD, 8'h00, 1, 8'hC3, 0);
        add(2, 0, RD, 8'h00, 0, 8'hC3, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].dut, vecs[i].vld, vecs[i].ctrl, vecs[i].d);
            @(posedge clk);
            #1;
            check_dut(vecs[i].dut, $sformatf("vec%0d", i), vecs[i].exp_tx, vecs[i].exp_dout, vecs[i].exp_err);
        end

        // asynchronous reset while a read is in flight on c
        @(negedge clk);
        drive(2, 1'b1, RD, 8'h00);
        @(posedge clk);
        #1;
        check_dut(2, "inflight", 1'b0, 8'hC3, 1'b0);
        drive(2, 1'b0, RD, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_dut(k, "async_reset", 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_dut(2, "held_reset", 1'b0, 8'h00, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_dut(2, $sformatf("post_reset%0d", k), 1'b0, 8'h00, 1'b0);
        end

        // both pointers back at 0 after reset
        @(negedge clk);
        drive(0, 1'b1, WD, 8'h4D);
        @(posedge clk);
        #1;
        check_dut(0, "ptr_reset_wr", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, RD, 8'h00);
        @(posedge clk);
        #1;
        check_dut(0, "ptr_reset_rd", 1'b1, 8'h4D, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, RD, 8'h00);
        @(posedge clk);
        #1;
        check_dut(0, "ptr_reset_idle", 1'b0, 8'h4D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port RAM that sits behind the SPI slave. It decodes the same 2-bit-control / data word (`rx_data`, `rx_valid`) and returns read data on `dout` / `tx_valid`. Compared with the first-generation RAM it adds:
- generic width and depth;
- optional address auto-increment for burst transfers, with wrap-around;
- a selectable 1- or 2-cycle read pipeline;
- a sticky error flag for out-of-range addresses.

## Interface
- MEM_WIDTH, 8, data width; `rx_data` is MEM_WIDTH+2 bits.
- MEM_DEPTH, 256, number of words, 2..2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; must be ≤ MEM_WIDTH.
- AUTO_INC, 1, 1 = pointer increments after each WR_DATA/RD_DATA; 0 = pointer holds.
- RD_LATENCY, 1, 1 or 2 clock edges from RD_DATA command to `tx_valid`.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
- rx_valid  in  1  qualifies `rx_data` for one cycle.
- rx_data  in  MEM_WIDTH+2  [MEM_WIDTH+1:MEM_WIDTH] = control (control_e), [MEM_WIDTH-1:0] = d_in.
- dout  out  MEM_WIDTH  read data, held between reads.
- tx_valid  out  1  one-cycle pulse per completed read.
- err  out  1  sticky out-of-range address flag.

## Operation
- Control encoding (control_e): 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- A command executes only on a clk edge with `rx_valid`=1. With `rx_valid`=0 there is no state change, no `tx_valid`, and `dout` holds. This includes control = RD_DATA.
- Address field: addr = d_in[ADDR_SIZE-1:0]. Upper d_in bits are ignored.
- WR_ADDR: if addr < MEM_DEPTH, then wr_ptr <= addr. Otherwise wr_ptr is unchanged and err <= 1.
- RD_ADDR: same rule, applied to rd_ptr.
- WR_DATA: mem[wr_ptr] <= d_in. If AUTO_INC, wr_ptr <= next(wr_ptr).
- RD_DATA: mem[rd_ptr] is sampled on the command edge into the read pipeline. If AUTO_INC, rd_ptr <= next(rd_ptr).
- next(p) = (p == MEM_DEPTH-1) ? 0 : p+1, so the pointer wraps at MEM_DEPTH, not at 2**ADDR_SIZE.
- Read sampling reflects every write committed on earlier edges. wr_ptr and rd_ptr are independent.
- Read pipeline:
  - RD_LATENCY=1: one stage feeding `dout` and `tx_valid`.
  - RD_LATENCY=2: an extra valid/data register stage.
  - Each stage holds a valid bit plus data. Back-to-back RD_DATA commands give back-to-back `tx_valid` pulses with no bubbles.
- `dout` updates only when a valid result leaves the pipeline. Otherwise it holds its last value.
- `err` is cleared only by reset. Once set it stays 1 and does not block later commands.
- Memory array is not reset; contents are undefined until written.
- Reset values: dout=0, tx_valid=0, err=0, wr_ptr=0, rd_ptr=0, all pipeline valid bits = 0.
- Reset asserted mid-operation: outputs and pointers go to their reset values immediately, without waiting for a clock edge. In-flight reads are discarded and never produce `tx_valid`. A WR_DATA on the same edge as reset assertion is not guaranteed to commit.

## Timing
- Write: a command presented in cycle n commits on the rising edge ending cycle n. A read issued in cycle n+1 of the same address returns the new data.
- Read, RD_LATENCY=1: RD_DATA presented in cycle n gives `dout`/`tx_valid` valid in cycle n+1.
- Read, RD_LATENCY=2: `dout`/`tx_valid` valid in cycle n+2.
- `tx_valid` is high for exactly one cycle per accepted RD_DATA. There is no backpressure; the SPI slave must consume `dout` in that cycle.
- Pointer updates from WR_ADDR/RD_ADDR take effect for a data command in the following cycle. Commands may be presented on every cycle.

## Test plan
- Reset: drive rst_n low asynchronously between clock edges while a read is in flight with RD_LATENCY=2. Expect dout=0, tx_valid=0, err=0 immediately, and no `tx_valid` pulse after release.
- Burst write/read, AUTO_INC=1, RD_LATENCY=1:
  - Stimulus: WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x5A, RD_ADDR 0x10, RD_DATA, RD_DATA on consecutive cycles.
  - Expect `dout` = 0xA5 then 0x5A, with `tx_valid` high on the two consecutive cycles after each RD_DATA.
- Wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then read addresses 0xFF and 0x00. Expect 0x11 and 0x22.
- Out-of-range, MEM_DEPTH=200:
  - Stimulus: WR_ADDR 0x05, WR_ADDR 0xC8, WR_DATA 0x77.
  - Expect err=1 from the cycle after the 0xC8 command, and mem[0x05]=0x77.
  - Also WR_ADDR 0xC7, WR_DATA 0x01, WR_DATA 0x02: expect mem[0xC7]=0x01 and mem[0x00]=0x02 (wrap at MEM_DEPTH).
- rx_valid gating: control = RD_DATA with `rx_valid`=0 for 5 cycles. Expect no `tx_valid`, `dout` unchanged, rd_ptr unchanged.
- AUTO_INC=0, RD_LATENCY=2:
  - Stimulus: WR_ADDR 0x03, WR_DATA 0x3C, WR_DATA 0xC3, RD_ADDR 0x03, then 3 RD_DATA.
  - Expect `dout` = 0xC3 three times, with `tx_valid` starting 2 cycles after the first RD_DATA.
